// File: rtl/watch_time_counter_if.sv
// Bus between the time-set stage and the watch time counter: the tick and
// load inputs plus the registered calendar fields and status pulses.
interface watch_time_counter_if;
    logic        tick1sec;
    logic        en_time;
    logic [47:0] bin_time;
    logic [7:0]  year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  second;
    logic        sec_pulse;
    logic        load_err;

    // Driver side: issues ticks and load requests, observes the time.
    modport master (
        output tick1sec, en_time, bin_time,
        input  year, month, day, hour, minute, second, sec_pulse, load_err
    );

    // Counter side.
    modport slave (
        input  tick1sec, en_time, bin_time,
        output year, month, day, hour, minute, second, sec_pulse, load_err
    );
endinterface

// File: rtl/watch_time_counter.sv
// Calendar/time-of-day counter for years 2000..2255. Advances one second per
// tick1sec strobe with full same-cycle carry up to the year, and accepts a
// validated six-field load that takes priority over the tick.
module watch_time_counter #(
    parameter logic [7:0] RESET_YEAR  = 8'd24,
    parameter logic [7:0] RESET_MONTH = 8'd1,
    parameter logic [7:0] RESET_DAY   = 8'd1
) (
    input  logic                 clk,
    input  logic                 rst,
    watch_time_counter_if.slave  bus
);

    // Field order matches bin_time, so a load is a plain struct assignment.
    typedef struct packed {
        logic [7:0] year;
        logic [7:0] month;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } time_t;

    localparam time_t RESET_TIME = '{
        year: RESET_YEAR, month: RESET_MONTH, day: RESET_DAY,
        hour: 8'd0, minute: 8'd0, second: 8'd0
    };

    // Days in a month; years 2100 and 2200 (offsets 100, 200) are not leap.
    // Out-of-range months return 31 and are rejected separately by the caller.
    function automatic logic [7:0] max_date(input logic [7:0] month, input logic [7:0] year);
        logic leap;
        leap = (year[1:0] == 2'b00) && (year != 8'd100) && (year != 8'd200);
        case (month)
            8'd4, 8'd6, 8'd9, 8'd11: max_date = 8'd30;
            8'd2:                    max_date = leap ? 8'd29 : 8'd28;
            default:                 max_date = 8'd31;
        endcase
    endfunction

    time_t time_q, time_d;
    time_t load_val;
    logic  sec_pulse_q, sec_pulse_d;
    logic  load_err_q, load_err_d;
    logic  load_ok;
    logic  sec_wrap, min_wrap, hour_wrap, day_wrap, month_wrap;

    assign load_val = bus.bin_time;

    // Load validity; the day limit uses the month/year being loaded.
    assign load_ok = (load_val.month >= 8'd1) && (load_val.month <= 8'd12) &&
                     (load_val.day >= 8'd1) &&
                     (load_val.day <= max_date(load_val.month, load_val.year)) &&
                     (load_val.hour <= 8'd23) && (load_val.minute <= 8'd59) &&
                     (load_val.second <= 8'd59);

    // Carry chain; the day limit uses the current (pre-increment) month/year.
    assign sec_wrap   = (time_q.second == 8'd59);
    assign min_wrap   = sec_wrap  && (time_q.minute == 8'd59);
    assign hour_wrap  = min_wrap  && (time_q.hour == 8'd23);
    assign day_wrap   = hour_wrap && (time_q.day == max_date(time_q.month, time_q.year));
    assign month_wrap = day_wrap  && (time_q.month == 8'd12);

    // Next state: load wins over tick; a rejected load also drops the tick.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        time_d      = time_q;
        sec_pulse_d = 1'b0;
        load_err_d  = 1'b0;
        if (bus.en_time) begin
            if (load_ok) begin
                time_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.tick1sec) begin
            sec_pulse_d   = 1'b1;
            time_d.second = sec_wrap ? 8'd0 : time_q.second + 8'd1;
            if (sec_wrap)   time_d.minute = min_wrap   ? 8'd0 : time_q.minute + 8'd1;
            if (min_wrap)   time_d.hour   = hour_wrap  ? 8'd0 : time_q.hour + 8'd1;
            if (hour_wrap)  time_d.day    = day_wrap   ? 8'd1 : time_q.day + 8'd1;
            if (day_wrap)   time_d.month  = month_wrap ? 8'd1 : time_q.month + 8'd1;
            if (month_wrap) time_d.year   = time_q.year + 8'd1;
        end
    end

    // State registers with asynchronous reset to the configured date.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q      <= RESET_TIME;
            sec_pulse_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            time_q      <= time_d;
            sec_pulse_q <= sec_pulse_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bus.year      = time_q.year;
    assign bus.month     = time_q.month;
    assign bus.day       = time_q.day;
    assign bus.hour      = time_q.hour;
    assign bus.minute    = time_q.minute;
    assign bus.second    = time_q.second;
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.load_err  = load_err_q;

endmodule
